// File: rtl/cubrt_arb_if.sv
// cubrt_arb_if: requester and engine signal bundle for cubrt_arb.
// master = requesters + engine side, slave = arbiter side.
`timescale 1ns/1ps
interface cubrt_arb_if #(
    parameter int N = 4,
    parameter int M = 27
);
    logic [N-1:0]       req;
    logic [N*3*M-1:0]   req_x;
    logic [N-1:0]       gnt;
    logic [N-1:0]       done;
    logic [N-1:0]       err;
    logic [M-1:0]       res;
    logic               busy;
    logic [3*M-1:0]     eng_x;
    logic               eng_st;
    logic [M-1:0]       eng_q;
    logic               eng_ok;

    modport master (
        output req, req_x, eng_q, eng_ok,
        input  gnt, done, err, res, busy, eng_x, eng_st
    );

    modport slave (
        input  req, req_x, eng_q, eng_ok,
        output gnt, done, err, res, busy, eng_x, eng_st
    );
endinterface

// File: rtl/cubrt_arb.sv
// cubrt_arb: round-robin arbiter sharing one cube-root engine among N requesters.
// Ports: clk, rst (async, active-high), bus (cubrt_arb_if.slave):
//   req/req_x in, gnt/done/err/res/busy out, eng_x/eng_st out, eng_q/eng_ok in.
// Optional: define CUBRT_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT cycles (err pulse).
`timescale 1ns/1ps
module cubrt_arb #(
    parameter int N       = 4,
    parameter int M       = 27,
    parameter int TIMEOUT = 40
) (
    input  logic         clk,
    input  logic         rst,
    cubrt_arb_if.slave   bus
);
    localparam int W  = 3 * M;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic            r_first;
    logic [W-1:0]    r_eng_x;
    logic [M-1:0]    r_res;
    logic [N-1:0]    r_gnt;
    logic [N-1:0]    r_done;
    logic [N-1:0]    r_err;
    logic            r_st;

    logic            w_hit;
    logic [IW-1:0]   w_sel;
    logic [IW-1:0]   w_nxt;
    logic [W-1:0]    w_slice;

`ifdef CUBRT_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   r_cnt;
`endif

    // first set request at or after r_ptr, wrapping modulo N
    always_comb begin
        int j;
        j     = 0;
        w_hit = 1'b0;
        w_sel = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(r_ptr) + k) % N;
            if (!w_hit && bus.req[j]) begin
                w_hit = 1'b1;
                w_sel = IW'(j);
            end
        end
    end

    assign w_nxt   = (w_sel == IW'(N - 1)) ? '0 : w_sel + 1'b1;
    assign w_slice = bus.req_x[int'(w_sel) * W +: W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_first <= 1'b0;
            r_eng_x <= '0;
            r_res   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_st    <= 1'b0;
`ifdef CUBRT_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            // pulses last one cycle unless re-armed below
            r_gnt  <= '0;
            r_done <= '0;
            r_err  <= '0;
            r_st   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_eng_x <= w_slice;
                        r_owner <= w_sel;
                        r_ptr   <= w_nxt;
                        r_gnt   <= N'(1) << w_sel;
                        r_st    <= 1'b1;
                        r_state <= START;
                    end
                end
                START: begin
                    r_first <= 1'b1;
`ifdef CUBRT_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_first <= 1'b0;
                    // eng_ok may still reflect the previous run in the first cycle
                    if (!r_first && bus.eng_ok) begin
                        r_res   <= bus.eng_q;
                        r_done  <= N'(1) << r_owner;
                        r_state <= IDLE;
                    end
`ifdef CUBRT_ARB_TIMEOUT_EN
                    else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_err   <= N'(1) << r_owner;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.res    = r_res;
    assign bus.busy   = (r_state != IDLE);
    assign bus.eng_x  = r_eng_x;
    assign bus.eng_st = r_st;
endmodule

// File: tb/tb_cubrt_arb.sv
// tb_cubrt_arb: scoreboard bench for cubrt_arb with a 27-step engine model.
// Define CUBRT_ARB_TIMEOUT_EN to also exercise the timeout path.
`timescale 1ns/1ps
module tb_cubrt_arb;
    localparam int N = 4;
    localparam int M = 27;
    localparam int W = 3 * M;

    typedef struct {
        int           idx;
        int           t0;
        logic [W-1:0] x;
        logic [M-1:0] r;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cubrt_arb_if #(.N(N), .M(M)) bus ();

    cubrt_arb #(.N(N), .M(M), .TIMEOUT(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int viol    = 0;

    ent_t gq[$];
    ent_t dq[$];
    ent_t eq[$];

    // req = raise toggles ^ grant toggles, each written by one process
    logic [N-1:0] up_tog = '0;
    logic [N-1:0] dn_tog = '0;
    assign bus.req = up_tog ^ dn_tog;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // engine model: result ready 28 cycles after the start pulse
    logic         withhold = 1'b0;
    logic [M-1:0] e_q = '0;
    logic         e_ok = 1'b0;
    int           e_cnt = 0;

    function automatic logic [M-1:0] cbrt(input logic [W-1:0] x);
        longint r;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= longint'(x)) r++;
        return M'(r);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (bus.eng_st) begin
            e_cnt <= 27;
            e_ok  <= 1'b0;
            e_q   <= cbrt(bus.eng_x);
        end else if (e_cnt > 0) begin
            e_cnt <= e_cnt - 1;
            if (e_cnt == 1 && !withhold) e_ok <= 1'b1;
        end
    end

    assign bus.eng_q  = e_q;
    assign bus.eng_ok = e_ok;

    // output monitor: pops scoreboard entries as gnt/done/err appear
    logic [N-1:0] pg = '0, pd = '0, pe = '0;
    logic         pst = 1'b0;

    always @(negedge clk) begin
        ent_t e;
        if (rst) begin
            pg = '0; pd = '0; pe = '0; pst = 1'b0;
        end else begin
            if ((bus.gnt & pg) != 0 || (bus.done & pd) != 0 ||
                (bus.err & pe) != 0 || (bus.eng_st && pst) ||
                (bus.gnt & bus.done) != 0 || (bus.gnt & bus.err) != 0 ||
                (bus.done & bus.err) != 0 ||
                (bus.eng_st != (bus.gnt != 0)))
                viol++;
            pg = bus.gnt; pd = bus.done; pe = bus.err; pst = bus.eng_st;

            if (bus.gnt != 0) begin
                if (gq.size() == 0) chk("gnt_spurious", bus.gnt, 0);
                else begin
                    e = gq.pop_front();
                    chk("gnt", bus.gnt, 128'(1) << e.idx);
                    chk("eng_x", bus.eng_x, e.x);
                    if (e.t0 >= 0) chk("gnt_lat", cyc - e.t0, 1);
                end
                dn_tog = dn_tog ^ bus.gnt;
            end
            if (bus.done != 0) begin
                if (dq.size() == 0) chk("done_spurious", bus.done, 0);
                else begin
                    e = dq.pop_front();
                    chk("done", bus.done, 128'(1) << e.idx);
                    chk("res", bus.res, e.r);
                    if (e.t0 >= 0) chk("done_lat", cyc - e.t0, 30);
                end
            end
            if (bus.err != 0) begin
                if (eq.size() == 0) chk("err_spurious", bus.err, 0);
                else begin
                    e = eq.pop_front();
                    chk("err", bus.err, 128'(1) << e.idx);
                    if (e.t0 >= 0) chk("err_lat", cyc - e.t0, 42);
                end
            end
        end
    end

    // call at a negedge with bus.req[i] low
    task automatic post(input int i, input logic [W-1:0] x,
                        input logic [M-1:0] r, input bit lat,
                        input bit to_err);
        ent_t e;
        e.idx = i;
        e.t0  = lat ? cyc : -1;
        e.x   = x;
        e.r   = r;
        bus.req_x[i*W +: W] = x;
        up_tog[i] = ~up_tog[i];
        gq.push_back(e);
        if (to_err) eq.push_back(e);
        else dq.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy || bus.req != 0 || gq.size() != 0 ||
                    dq.size() != 0 || eq.size() != 0) && n < 2000);
        if (n >= 2000) chk("wait_idle_timeout", 1, 0);
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done[i] && n < 200);
        if (!bus.done[i]) chk("wait_done_timeout", 1, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, bus.gnt, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_eng_st"}, bus.eng_st, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_eng_x"}, bus.eng_x, 0);
        chk({tag, "_res"}, bus.res, 0);
    endtask

    initial begin
        bus.req_x = '0;
        repeat (3) @(negedge clk);
        chk_zero("rst");
        rst = 1'b0;
        @(negedge clk);

        // single request, cube root of 8
        post(0, 8, 2, 1, 0);
        wait_idle();

        // requester 3 first (ptr=1), then 0 and 3 with ptr wrapped to 0
        post(3, 27, 3, 1, 0);
        wait_idle();
        post(0, 1, 1, 1, 0);
        post(3, 64, 4, 0, 0);
        wait_idle();

        // full contention, ptr back at 0
        post(0, 1, 1, 1, 0);
        post(1, 8, 2, 0, 0);
        post(2, 27, 3, 0, 0);
        post(3, 64, 4, 0, 0);
        wait_idle();

        // back-to-back: re-request in the done cycle
        post(0, 64, 4, 1, 0);
        wait_done(0);
        post(0, 125, 5, 1, 0);
        wait_idle();

        // reset in the middle of WAIT
        post(1, 1000, 10, 0, 0);
        repeat (12) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_zero("midrst");
        dq.delete();
        gq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        // ptr restarted at 0, so 1 precedes 2
        post(1, 1000, 10, 1, 0);
        post(2, 343, 7, 0, 0);
        wait_idle();

`ifdef CUBRT_ARB_TIMEOUT_EN
        withhold = 1'b1;
        post(3, 8, 2, 1, 1);
        wait_idle();
        chk("res_after_err", bus.res, 7);
        withhold = 1'b0;
        post(0, 27, 3, 1, 0);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        chk("pulse_rules", viol, 0);
        chk("gq_left", gq.size(), 0);
        chk("dq_left", dq.size(), 0);
        chk("eq_left", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
